speedpong_key_conditioner: RTL

SPEEDPONG_KEY_CONDITIONER -- requirements
Module: speedpong_key_conditioner

---
 rtl/speedpong_input_pkg.sv | 26 ++
 rtl/speedpong_key_debounce.sv | 117 +++++++++++
 rtl/speedpong_key_conditioner.sv | 34 +++
 3 files changed

// File: rtl/speedpong_input_pkg.sv
// Shared types and default timing for the push-button conditioning path.
package speedpong_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_t;

  localparam int DEF_N_KEYS          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/speedpong_key_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional auto-repeat
// (SPEEDPONG_KEY_AUTOREPEAT_EN). Press/release pulse 2 + DEBOUNCE_CYCLES after a clean edge.
module speedpong_key_debounce
  import speedpong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef SPEEDPONG_KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  logic rep_phase;
`endif

  logic          sync_q1;
  logic          sync_q2;
  key_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // Inverted before the first flop so a cleared synchronizer reads as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= ~key_n;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef SPEEDPONG_KEY_AUTOREPEAT_EN
      rep_phase   <= 1'b0;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        // The IDLE->PRESS_WAIT cycle counts as the first stable sample.
        PRESS_WAIT: begin
          if (!sync_q2) begin
            state <= IDLE;
          end else if (cnt_inc == DB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
`ifdef SPEEDPONG_KEY_AUTOREPEAT_EN
            rep_phase <= 1'b0;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (!sync_q2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef SPEEDPONG_KEY_AUTOREPEAT_EN
          else if (cnt == (rep_phase ? RP_LAST : RD_LAST)) begin
            key_press <= 1'b1;
            cnt       <= '0;
            rep_phase <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync_q2) begin
            state <= HELD;
            cnt   <= '0;
`ifdef SPEEDPONG_KEY_AUTOREPEAT_EN
            rep_phase <= 1'b0;
`endif
          end else if (cnt_inc == DB_LAST) begin
            state       <= IDLE;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/speedpong_key_conditioner.sv
// N_KEYS independent debounced button channels; auto-repeat under SPEEDPONG_KEY_AUTOREPEAT_EN.
// Pulses arrive 2 + DEBOUNCE_CYCLES cycles after a clean edge on key_n.
module speedpong_key_conditioner
  import speedpong_input_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    speedpong_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_debounce (
      .clk         (CLOCK_50),
      .rst_n       (RESET_N),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule
